gf180mcu_ws_io__pwr_seq: RTL and testbench
==========================================

GF180MCU_WS_IO__PWR_SEQ -- requirements
Module: gf180mcu_ws_io__pwr_seq

Interface
REQ-001 SHALL have parameter NSEG, default 4, number of IO pad supply segments (DVDD/DVSS pad groups), range 1..8.
REQ-002 SHALL have parameter DEB_CYC, default 16, consecutive cycles all PG must be high before ramp-up.
REQ-003 SHALL have parameter SETTLE_CYC, default 32, cycles between SEG_EN[i] rising and ISO[i] falling.
REQ-004 CLK  in  1  sole clock, all state on rising edge.
REQ-005 RESETN  in  1  reset, synchronous, active-low.
REQ-006 EN  in  1  power-up request; level-sensitive; 0 requests power-down.
REQ-007 PG  in  NSEG  per-segment supply-good from pad-ring monitors; asynchronous.
REQ-008 CLR_FAULT  in  1  fault clear; honoured only while EN=0.
REQ-009 SEG_EN  out  NSEG  per-segment pad-driver enable, active-high.
REQ-010 ISO  out  NSEG  per-segment core/pad isolation, active-high.
REQ-011 READY  out  1  all segments enabled and de-isolated.
REQ-012 FAULT  out  1  sticky supply-loss flag.
REQ-013 STATE  out  3  current FSM state encoding, for debug.

Function
REQ-014 PG SHALL pass through a 2-flop synchronizer; all decisions use synchronized PG (2-cycle latency).
REQ-015 FSM states SHALL be OFF, DEBOUNCE, RAMP, SETTLE, READY, SHUTDOWN, FAULT.
REQ-016 OFF: SEG_EN=0, ISO=all-ones, READY=0; EN=1 -> DEBOUNCE with debounce counter cleared.
REQ-017 DEBOUNCE: counter increments each cycle all sync PG=1, clears on any 0; reaching DEB_CYC-1 with PG all-1 -> RAMP, idx=0; EN=0 -> OFF.
REQ-018 RAMP: set SEG_EN[idx] (registered, visible next cycle); -> SETTLE with settle counter cleared; lasts exactly one cycle.
REQ-019 SETTLE: after SETTLE_CYC cycles clear ISO[idx]; idx=NSEG-1 -> READY, else idx+1 -> RAMP.
REQ-020 Enabled segments SHALL come up strictly in ascending index order; segment i+1 never enabled before ISO[i]=0.
REQ-021 READY: READY=1 registered; EN=0 -> SHUTDOWN with idx=NSEG-1; READY drops the cycle SHUTDOWN is entered.
REQ-022 SHUTDOWN: per segment, two cycles: set ISO[idx], then next cycle clear SEG_EN[idx]; descending idx; after idx 0 -> OFF.
REQ-023 EN=0 during RAMP/SETTLE SHALL enter SHUTDOWN starting at the highest currently enabled segment; un-enabled segments untouched.
REQ-024 Any sync PG=0 in RAMP, SETTLE, READY or SHUTDOWN -> FAULT: ISO=all-ones and SEG_EN=0 on the same next edge, FAULT=1, READY=0.
REQ-025 FAULT state SHALL hold until CLR_FAULT=1 and EN=0 in the same cycle -> OFF; CLR_FAULT with EN=1 ignored.
REQ-026 Simultaneous PG loss and EN=0 SHALL resolve as FAULT.
REQ-027 Invariant: ISO[i]=0 implies SEG_EN[i]=1 in every cycle.
REQ-028 Counters SHALL be $clog2(param)+1 bits wide and never wrap; saturate at terminal count.
REQ-029 All outputs SHALL be registered, no combinational input-to-output path.

Reset
REQ-030 RESETN=0 at a rising edge SHALL force OFF, SEG_EN=0, ISO=all-ones, READY=0, FAULT=0, STATE=OFF, idx=0, counters=0, synchronizer flops=0.
REQ-031 Reset mid-sequence (any state) SHALL take effect at the same edge with no shutdown ordering; reset overrides all inputs.

Structure
REQ-032 State encoding enum and default parameter constants SHALL live in package gf180mcu_ws_io__pwr_seq_pkg.
REQ-033 The PG synchronizer SHALL be sub-module gf180mcu_ws_io__sync2, instantiated NSEG bits wide.

Verification
REQ-034 Nominal: PG=4'hF, EN=1 -> READY=1 at cycle 2+16+4*(1+32)+1 after EN; SEG_EN bits rise in order 0..3, each ISO[i] falls 32 cycles after SEG_EN[i].
REQ-035 Bounce: PG[2] pulses low 1 cycle at debounce count 10 -> counter restarts; RAMP entered 16 cycles after PG stable.
REQ-036 Shutdown: from READY, EN=0 -> ISO[3] set, next cycle SEG_EN[3] cleared, ... OFF after 8 cycles.
REQ-037 Fault: in READY, PG[1]=0 -> 3 cycles later SEG_EN=0, ISO=4'hF, FAULT=1; CLR_FAULT with EN=1 ignored; with EN=0 -> OFF, FAULT=0.
REQ-038 Abort/reset: EN=0 during SETTLE of idx=1 -> segments 1,0 shut down in order; RESETN=0 in SETTLE -> all outputs reset values next edge.
REQ-039 Assertion on REQ-027 invariant SHALL be checked in every test.

Source files
------------

// File: rtl/gf180mcu_ws_io__pwr_seq_pkg.sv
// Shared types and defaults for the GF180MCU IO pad-ring power sequencer.
// The state encoding is visible on the debug STATE output.
package gf180mcu_ws_io__pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_RAMP     = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_READY    = 3'd4,
        ST_SHUTDOWN = 3'd5,
        ST_FAULT    = 3'd6
    } pwr_state_e;

    localparam int DEF_NSEG       = 4;
    localparam int DEF_DEB_CYC    = 16;
    localparam int DEF_SETTLE_CYC = 32;

    // One spare bit above the terminal count so a counter can never wrap.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/gf180mcu_ws_io__pwr_seq_if.sv
// Control/status bundle between the pad-ring power sequencer and its controller.
// All signals are levels with no valid/ready handshake: en, pg and clr_fault are
// sampled on every rising clock edge, and every sequencer output is a register.
interface gf180mcu_ws_io__pwr_seq_if
    import gf180mcu_ws_io__pwr_seq_pkg::*;
#(
    parameter int NSEG = DEF_NSEG
);
    logic            en;
    logic [NSEG-1:0] pg;
    logic            clr_fault;
    logic [NSEG-1:0] seg_en;
    logic [NSEG-1:0] iso;
    logic            ready;
    logic            fault;
    pwr_state_e      state;

    modport slave (
        input  en, pg, clr_fault,
        output seg_en, iso, ready, fault, state
    );

    modport master (
        output en, pg, clr_fault,
        input  seg_en, iso, ready, fault, state
    );
endinterface

// File: rtl/gf180mcu_ws_io__sync2.sv
// Two-flop synchronizer bank for asynchronous level inputs.
module gf180mcu_ws_io__sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/gf180mcu_ws_io__pwr_seq.sv
// Pad-ring supply sequencer: debounces supply-good, enables segments in ascending
// order with an isolation settle window, shuts down in reverse, and latches supply loss.
module gf180mcu_ws_io__pwr_seq
    import gf180mcu_ws_io__pwr_seq_pkg::*;
#(
    parameter int NSEG       = DEF_NSEG,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input logic                      clk_i,
    input logic                      resetn_i,
    gf180mcu_ws_io__pwr_seq_if.slave pwr_if
);
    localparam int DEB_W = cnt_width(DEB_CYC);
    localparam int SET_W = cnt_width(SETTLE_CYC);
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSEG - 1);

    pwr_state_e      state_q,   state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             sd_ph_q,   sd_ph_d;
    logic [NSEG-1:0]  seg_en_q,  seg_en_d;
    logic [NSEG-1:0]  iso_q,     iso_d;
    logic             ready_q,   ready_d;
    logic             fault_q,   fault_d;

    logic [NSEG-1:0]  pg_sync;
    logic             pg_all;
    logic             pg_lost;
    logic             powered;

    gf180mcu_ws_io__sync2 #(
        .W (NSEG)
    ) u_pg_sync (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .d_i      (pwr_if.pg),
        .q_o      (pg_sync)
    );

    assign pg_all  = &pg_sync;
    assign pg_lost = ~pg_all;
    assign powered = (state_q == ST_RAMP) || (state_q == ST_SETTLE) ||
                     (state_q == ST_READY) || (state_q == ST_SHUTDOWN);

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        set_cnt_d = set_cnt_q;
        idx_d     = idx_q;
        sd_ph_d   = sd_ph_q;
        seg_en_d  = seg_en_q;
        iso_d     = iso_q;
        ready_d   = 1'b0;
        fault_d   = fault_q;

        case (state_q)
            ST_OFF: begin
                seg_en_d = '0;
                iso_d    = '1;
                if (pwr_if.en) begin
                    state_d   = ST_DEBOUNCE;
                    deb_cnt_d = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!pwr_if.en) begin
                    state_d = ST_OFF;
                end else if (!pg_all) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_RAMP;
                    idx_d   = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ST_RAMP: begin
                // Segment idx is not enabled yet, so an abort starts one below it.
                if (!pwr_if.en) begin
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_SHUTDOWN;
                        idx_d   = idx_q - 1'b1;
                        sd_ph_d = 1'b0;
                    end
                end else begin
                    seg_en_d[idx_q] = 1'b1;
                    state_d         = ST_SETTLE;
                    set_cnt_d       = '0;
                end
            end
            ST_SETTLE: begin
                if (!pwr_if.en) begin
                    state_d = ST_SHUTDOWN;
                    sd_ph_d = 1'b0;
                end else if (set_cnt_q == SET_LAST) begin
                    iso_d[idx_q] = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_READY;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RAMP;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (!pwr_if.en) begin
                    state_d = ST_SHUTDOWN;
                    idx_d   = IDX_LAST;
                    sd_ph_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SHUTDOWN: begin
                // Isolate first, drop the driver enable on the following cycle.
                if (!sd_ph_q) begin
                    iso_d[idx_q] = 1'b1;
                    sd_ph_d      = 1'b1;
                end else begin
                    seg_en_d[idx_q] = 1'b0;
                    sd_ph_d         = 1'b0;
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                seg_en_d = '0;
                iso_d    = '1;
                fault_d  = 1'b1;
                if (pwr_if.clr_fault && !pwr_if.en) begin
                    state_d = ST_OFF;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_OFF;
                seg_en_d = '0;
                iso_d    = '1;
            end
        endcase

        // Supply loss beats every other request, including a concurrent EN drop.
        if (pg_lost && powered) begin
            state_d  = ST_FAULT;
            seg_en_d = '0;
            iso_d    = '1;
            fault_d  = 1'b1;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= ST_OFF;
            deb_cnt_q <= '0;
            set_cnt_q <= '0;
            idx_q     <= '0;
            sd_ph_q   <= 1'b0;
            seg_en_q  <= '0;
            iso_q     <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            set_cnt_q <= set_cnt_d;
            idx_q     <= idx_d;
            sd_ph_q   <= sd_ph_d;
            seg_en_q  <= seg_en_d;
            iso_q     <= iso_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pwr_if.seg_en = seg_en_q;
    assign pwr_if.iso    = iso_q;
    assign pwr_if.ready  = ready_q;
    assign pwr_if.fault  = fault_q;
    assign pwr_if.state  = state_q;
endmodule

// File: tb/tb_gf180mcu_ws_io__pwr_seq.sv
// Self-checking bench for the pad-ring power sequencer: timeline model of ramp-up
// and shutdown, randomized bounce/fault/abort/reset points, invariant checked every cycle.
module tb_gf180mcu_ws_io__pwr_seq;
    import gf180mcu_ws_io__pwr_seq_pkg::*;

    localparam int NSEG = 4;
    localparam int DEB  = 16;
    localparam int SET  = 32;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    bit   inv_on = 1'b0;
    int   inv_prints = 0;
    logic [2*NSEG:0] exp_q[$];

    always #5 clk = ~clk;

    gf180mcu_ws_io__pwr_seq_if #(.NSEG(NSEG)) pwr_if ();

    gf180mcu_ws_io__pwr_seq #(
        .NSEG       (NSEG),
        .DEB_CYC    (DEB),
        .SETTLE_CYC (SET)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .pwr_if   (pwr_if.slave)
    );

    // Ramp-up timeline measured in edges after the first edge that samples EN=1;
    // t_ramp is the edge at which the sequencer enters RAMP for segment 0.
    function automatic logic [NSEG-1:0] up_seg_en(int t, int t_ramp);
        logic [NSEG-1:0] r;
        for (int i = 0; i < NSEG; i++) r[i] = (t >= t_ramp + 1 + i * (SET + 1));
        return r;
    endfunction

    function automatic logic [NSEG-1:0] up_iso(int t, int t_ramp);
        logic [NSEG-1:0] r;
        for (int i = 0; i < NSEG; i++) r[i] = (t < t_ramp + 1 + i * (SET + 1) + SET);
        return r;
    endfunction

    function automatic logic up_ready(int t, int t_ramp);
        return (t >= t_ramp + NSEG * (SET + 1) + 1);
    endfunction

    // Shutdown timeline: edge 1 samples EN=0; segments top..0 each take two edges.
    function automatic logic [NSEG-1:0] sd_seg_en(int t, int top, logic [NSEG-1:0] base);
        logic [NSEG-1:0] r;
        r = base;
        for (int i = 0; i <= top; i++) if (t >= 3 + 2 * (top - i)) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [NSEG-1:0] sd_iso(int t, int top, logic [NSEG-1:0] base);
        logic [NSEG-1:0] r;
        r = base;
        for (int i = 0; i <= top; i++) if (t >= 2 + 2 * (top - i)) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (inv_on) begin
            checks++;
            if (((~pwr_if.seg_en) & (~pwr_if.iso)) !== '0) begin
                errors++;
                if (inv_prints < 10) begin
                    inv_prints++;
                    $display("FAIL invariant iso0_implies_en seg_en=%b iso=%b", pwr_if.seg_en, pwr_if.iso);
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic goto_ready();
        int n;
        do_reset();
        pwr_if.pg = '1;
        pwr_if.clr_fault = 1'b0;
        pwr_if.en = 1'b1;
        n = 0;
        while (pwr_if.ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (pwr_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL goto_ready ready=%b after %0d cycles, required 1", pwr_if.ready, n);
        end
    endtask

    task automatic test_reset();
        pwr_if.en = 1'b1;
        pwr_if.pg = '1;
        pwr_if.clr_fault = 1'b0;
        resetn = 1'b0;
        repeat (3) step();
        checks += 5;
        if (pwr_if.seg_en !== '0) begin errors++; $display("FAIL reset_seg_en got=%b exp=0", pwr_if.seg_en); end
        if (pwr_if.iso !== '1) begin errors++; $display("FAIL reset_iso got=%b exp=all-ones", pwr_if.iso); end
        if (pwr_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", pwr_if.ready); end
        if (pwr_if.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", pwr_if.fault); end
        if (pwr_if.state !== ST_OFF) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", pwr_if.state, ST_OFF); end
        pwr_if.en = 1'b0;
        resetn = 1'b1;
        step();
        checks++;
        if (pwr_if.state !== ST_OFF) begin errors++; $display("FAIL idle_off got=%0d exp=%0d", pwr_if.state, ST_OFF); end
        inv_on = 1'b1;
    endtask

    task automatic test_power_up();
        logic [2*NSEG:0] exp;
        logic [2*NSEG:0] got;
        int ready_t;
        int t_ramp;
        pwr_if.en = 1'b0;
        pwr_if.pg = '0;
        do_reset();
        step();
        // PG and EN rise together: PG becomes visible two edges late, then DEB qualifying edges.
        t_ramp = 2 + DEB;
        for (int t = 1; t <= 160; t++)
            exp_q.push_back({up_seg_en(t, t_ramp), up_iso(t, t_ramp), up_ready(t, t_ramp)});
        pwr_if.en = 1'b1;
        pwr_if.pg = '1;
        ready_t = -1;
        for (int t = 1; t <= 160; t++) begin
            step();
            exp = exp_q.pop_front();
            got = {pwr_if.seg_en, pwr_if.iso, pwr_if.ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL power_up t=%0d got seg_en/iso/ready=%b exp=%b", t, got, exp);
            end
            if (pwr_if.ready === 1'b1 && ready_t < 0) ready_t = t;
        end
        checks += 2;
        if (ready_t != 2 + DEB + NSEG * (1 + SET) + 1) begin
            errors++;
            $display("FAIL ready_latency got=%0d exp=%0d", ready_t, 2 + DEB + NSEG * (1 + SET) + 1);
        end
        if (pwr_if.state !== ST_READY) begin errors++; $display("FAIL ready_state got=%0d exp=%0d", pwr_if.state, ST_READY); end
    endtask

    task automatic test_shutdown();
        logic [2*NSEG:0] exp;
        logic [2*NSEG:0] got;
        pwr_if.en = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            exp = {sd_seg_en(t, NSEG - 1, '1), sd_iso(t, NSEG - 1, '0), 1'b0};
            got = {pwr_if.seg_en, pwr_if.iso, pwr_if.ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL shutdown t=%0d got seg_en/iso/ready=%b exp=%b", t, got, exp);
            end
            if (t == 2 * NSEG + 1) begin
                checks++;
                if (pwr_if.state !== ST_OFF) begin errors++; $display("FAIL shutdown_off t=%0d got=%0d exp=%0d", t, pwr_if.state, ST_OFF); end
            end
        end
    endtask

    task automatic test_bounce(int c, int b);
        int t;
        int ramp_t;
        pwr_if.en = 1'b0;
        pwr_if.pg = '1;
        do_reset();
        step();
        step();
        pwr_if.en = 1'b1;
        ramp_t = -1;
        t = 1;
        while (ramp_t < 0 && t <= 60) begin
            if (t == c) pwr_if.pg[b] = 1'b0;
            if (t == c + 1) pwr_if.pg = '1;
            step();
            if (pwr_if.state === ST_RAMP) ramp_t = t;
            t++;
        end
        // Low pulse sampled at edge c is seen at c+2; RAMP follows DEB clean edges later.
        checks++;
        if (ramp_t != c + 2 + DEB) begin
            errors++;
            $display("FAIL bounce_ramp c=%0d seg=%0d got=%0d exp=%0d", c, b, ramp_t, c + 2 + DEB);
        end
        pwr_if.en = 1'b0;
        step();
        checks++;
        if (pwr_if.state !== ST_OFF || pwr_if.seg_en !== '0) begin
            errors++;
            $display("FAIL ramp_abort got state=%0d seg_en=%b exp state=%0d seg_en=0", pwr_if.state, pwr_if.seg_en, ST_OFF);
        end
    endtask

    task automatic test_fault(int f);
        goto_ready();
        pwr_if.pg[f] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            step();
            checks++;
            if (t < 3) begin
                if ({pwr_if.seg_en, pwr_if.iso, pwr_if.ready, pwr_if.fault} !== {{NSEG{1'b1}}, {NSEG{1'b0}}, 2'b10}) begin
                    errors++;
                    $display("FAIL fault_pre t=%0d seg_en=%b iso=%b ready=%b fault=%b exp still ready", t, pwr_if.seg_en, pwr_if.iso, pwr_if.ready, pwr_if.fault);
                end
            end else begin
                if ({pwr_if.seg_en, pwr_if.iso, pwr_if.ready, pwr_if.fault} !== {{NSEG{1'b0}}, {NSEG{1'b1}}, 2'b01} || pwr_if.state !== ST_FAULT) begin
                    errors++;
                    $display("FAIL fault_hit t=%0d seg_en=%b iso=%b ready=%b fault=%b state=%0d exp 0/all-ones/0/1/%0d", t, pwr_if.seg_en, pwr_if.iso, pwr_if.ready, pwr_if.fault, pwr_if.state, ST_FAULT);
                end
            end
        end
        pwr_if.pg = '1;
        pwr_if.clr_fault = 1'b1;
        repeat (4) step();
        checks++;
        if (pwr_if.state !== ST_FAULT || pwr_if.fault !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_en got state=%0d fault=%b exp state=%0d fault=1", pwr_if.state, pwr_if.fault, ST_FAULT);
        end
        pwr_if.en = 1'b0;
        step();
        checks++;
        if (pwr_if.state !== ST_OFF || pwr_if.fault !== 1'b0 || pwr_if.iso !== '1) begin
            errors++;
            $display("FAIL clr_fault got state=%0d fault=%b iso=%b exp state=%0d fault=0", pwr_if.state, pwr_if.fault, pwr_if.iso, ST_OFF);
        end
        pwr_if.clr_fault = 1'b0;
    endtask

    task automatic test_simul(int f);
        goto_ready();
        pwr_if.pg[f] = 1'b0;
        step();
        step();
        pwr_if.en = 1'b0;
        step();
        checks++;
        if (pwr_if.state !== ST_FAULT || pwr_if.fault !== 1'b1 || pwr_if.seg_en !== '0) begin
            errors++;
            $display("FAIL simul_loss_en got state=%0d fault=%b seg_en=%b exp state=%0d fault=1 seg_en=0", pwr_if.state, pwr_if.fault, pwr_if.seg_en, ST_FAULT);
        end
        pwr_if.pg = '1;
    endtask

    task automatic test_abort(int k);
        int n;
        logic [2*NSEG:0] exp;
        logic [2*NSEG:0] got;
        pwr_if.en = 1'b0;
        pwr_if.pg = '1;
        do_reset();
        step();
        pwr_if.en = 1'b1;
        n = 0;
        while (pwr_if.seg_en !== NSEG'(3) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (pwr_if.seg_en !== NSEG'(3)) begin
            errors++;
            $display("FAIL abort_reach got seg_en=%b exp=%b", pwr_if.seg_en, NSEG'(3));
        end
        repeat (k) step();
        pwr_if.en = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            step();
            exp = {sd_seg_en(t, 1, NSEG'(3)), sd_iso(t, 1, ~NSEG'(1)), 1'b0};
            got = {pwr_if.seg_en, pwr_if.iso, pwr_if.ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort k=%0d t=%0d got seg_en/iso/ready=%b exp=%b", k, t, got, exp);
            end
            if (t == 5) begin
                checks++;
                if (pwr_if.state !== ST_OFF) begin errors++; $display("FAIL abort_off got=%0d exp=%0d", pwr_if.state, ST_OFF); end
            end
        end
    endtask

    task automatic test_reset_mid(int k);
        int n;
        pwr_if.en = 1'b0;
        pwr_if.pg = '1;
        do_reset();
        step();
        pwr_if.en = 1'b1;
        n = 0;
        while (pwr_if.seg_en !== NSEG'(1) && n < 100) begin
            step();
            n++;
        end
        repeat (k) step();
        checks++;
        if (pwr_if.state !== ST_SETTLE) begin errors++; $display("FAIL mid_settle got=%0d exp=%0d", pwr_if.state, ST_SETTLE); end
        resetn = 1'b0;
        step();
        checks++;
        if ({pwr_if.seg_en, pwr_if.iso, pwr_if.ready, pwr_if.fault} !== {{NSEG{1'b0}}, {NSEG{1'b1}}, 2'b00} || pwr_if.state !== ST_OFF) begin
            errors++;
            $display("FAIL mid_reset seg_en=%b iso=%b ready=%b fault=%b state=%0d exp reset values", pwr_if.seg_en, pwr_if.iso, pwr_if.ready, pwr_if.fault, pwr_if.state);
        end
        pwr_if.en = 1'b0;
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn = 1'b0;
        pwr_if.en = 1'b0;
        pwr_if.pg = '0;
        pwr_if.clr_fault = 1'b0;
        test_reset();
        test_power_up();
        test_shutdown();
        test_bounce(10, 2);
        test_bounce($urandom_range(2, 14), $urandom_range(0, NSEG - 1));
        test_bounce($urandom_range(2, 14), $urandom_range(0, NSEG - 1));
        test_fault(1);
        test_fault($urandom_range(0, NSEG - 1));
        test_simul($urandom_range(0, NSEG - 1));
        test_abort($urandom_range(0, 30));
        test_abort($urandom_range(0, 30));
        test_reset_mid($urandom_range(0, 25));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
